// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates IF-fetch and MEM-data ports onto one single-port fixed-latency memory.
// Latency: request in cycle 0 -> mem_en in cycle 1 -> ack in cycle MEM_LAT+2; one transaction at a time.
// Backpressure: requests are held until their ack; stall outputs flag a pending, unacked request.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MEM_LAT       = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
  localparam int STK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_LAT - 1);
  localparam logic [STK_W-1:0] STK_MAX   = STK_W'(MAX_DM_STREAK);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_dm_q, owner_dm_d;   // 1: data port owns the current transaction
  logic              cancel_q, cancel_d;       // in-flight fetch has been flushed
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [STK_W-1:0]  streak_q, streak_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic if_elig;
  logic grant_dm;

  // Next-state: arbitration in IDLE, fixed-latency sequencing, response capture
  always_comb begin
    state_d    = state_q;
    owner_dm_d = owner_dm_q;
    cancel_d   = cancel_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wcnt_d     = wcnt_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    grant_dm   = 1'b0;
    if_elig    = if_req & ~if_cancel;

    case (state_q)
      ST_IDLE: begin
        if (dm_req || if_elig) begin
          // Data wins unless a waiting fetch has already been passed over MAX_DM_STREAK times
          grant_dm   = dm_req && !(if_elig && (streak_q == STK_MAX));
          state_d    = ST_ISSUE;
          owner_dm_d = grant_dm;
          cancel_d   = 1'b0;
          if (grant_dm) begin
            addr_d   = dm_addr;
            we_d     = dm_we;
            wdata_d  = dm_wdata;
            if (if_elig) begin
              streak_d = (streak_q == STK_MAX) ? streak_q : streak_q + 1'b1;
            end else begin
              streak_d = '0;
            end
          end else begin
            addr_d   = if_addr;
            we_d     = 1'b0;
            wdata_d  = '0;
            streak_d = '0;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        wcnt_d  = '0;
        if (!owner_dm_q && if_cancel) cancel_d = 1'b1;
      end
      ST_WAIT: begin
        if (!owner_dm_q && if_cancel) cancel_d = 1'b1;
        if (wcnt_q == LAST_WAIT) begin
          state_d = ST_RESP;
          if (owner_dm_q) begin
            dm_rdata_d = we_q ? '0 : mem_rdata;
          end else if (!(cancel_q || if_cancel)) begin
            // A flushed fetch leaves the previous instruction word in place
            if_rdata_d = mem_rdata;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latch registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_dm_q <= 1'b0;
      cancel_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wcnt_q     <= '0;
      streak_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_dm_q <= owner_dm_d;
      cancel_q   <= cancel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wcnt_q     <= wcnt_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Output decode; a cancel arriving during RESP still kills the fetch ack
  always_comb begin
    mem_en    = (state_q == ST_ISSUE);
    mem_we    = mem_en & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    dm_ack    = (state_q == ST_RESP) & owner_dm_q;
    if_ack    = (state_q == ST_RESP) & ~owner_dm_q & ~cancel_q & ~if_cancel;
    if_rdata  = if_rdata_q;
    dm_rdata  = dm_rdata_q;
    if_stall  = if_req & ~if_ack;
    dm_stall  = dm_req & ~dm_ack;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=1, MAX_DM_STREAK=4.
// A one-cycle-latency memory model returns a value derived from the address.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_cancel, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack, if_stall, dm_ack, dm_stall, mem_en, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_DM_STREAK(4)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h10) return 32'h00500093;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Read data appears one cycle after the mem_en cycle
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_val(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs for the new cycle are driven
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  logic [31:0] exp_seq [6];
  int g;

  initial begin
    reset = 1'b0; if_req = 0; if_cancel = 0; if_addr = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    repeat (3) tick();
    settle();
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_if_ack", 32'(if_ack), 0);
    chk("rst_dm_ack", 32'(dm_ack), 0);
    reset = 1'b1;
    tick(); settle();
    chk("idle_mem_en", 32'(mem_en), 0);
    chk("idle_mem_addr", mem_addr, 0);

    // 1: single fetch
    tick(); if_req = 1; if_addr = 32'h10; settle();
    chk("t1_stall_c0", 32'(if_stall), 1);
    chk("t1_mem_en_c0", 32'(mem_en), 0);
    tick(); settle();
    chk("t1_mem_en_c1", 32'(mem_en), 1);
    chk("t1_mem_addr_c1", mem_addr, 32'h10);
    chk("t1_mem_we_c1", 32'(mem_we), 0);
    tick(); settle();
    chk("t1_ack_c2", 32'(if_ack), 0);
    tick(); settle();
    chk("t1_ack_c3", 32'(if_ack), 1);
    chk("t1_rdata_c3", if_rdata, 32'h00500093);
    chk("t1_stall_c3", 32'(if_stall), 0);
    tick(); if_req = 0;
    tick();

    // 2: simultaneous requests, data first
    tick(); if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = 32'h20; settle();
    tick(); settle();
    chk("t2_mem_addr_c1", mem_addr, 32'h20);
    chk("t2_mem_en_c1", 32'(mem_en), 1);
    tick(); settle();
    tick(); settle();
    chk("t2_dm_ack_c3", 32'(dm_ack), 1);
    chk("t2_dm_rdata_c3", dm_rdata, 32'hA5A5_0020);
    chk("t2_if_ack_c3", 32'(if_ack), 0);
    chk("t2_if_stall_c3", 32'(if_stall), 1);
    tick(); dm_req = 0; settle();
    chk("t2_mem_en_c4", 32'(mem_en), 0);
    chk("t2_dm_ack_c4", 32'(dm_ack), 0);
    tick(); settle();
    chk("t2_mem_en_c5", 32'(mem_en), 1);
    chk("t2_mem_addr_c5", mem_addr, 32'h40);
    tick(); settle();
    chk("t2_if_stall_c6", 32'(if_stall), 1);
    tick(); settle();
    chk("t2_if_ack_c7", 32'(if_ack), 1);
    chk("t2_if_rdata_c7", if_rdata, 32'hA5A5_0040);
    tick(); if_req = 0;
    tick();

    // 3: data write
    tick(); dm_req = 1; dm_we = 1; dm_addr = 32'h8; dm_wdata = 32'hDEADBEEF;
    tick(); settle();
    chk("t3_mem_en_c1", 32'(mem_en), 1);
    chk("t3_mem_we_c1", 32'(mem_we), 1);
    chk("t3_mem_wdata_c1", mem_wdata, 32'hDEADBEEF);
    chk("t3_mem_addr_c1", mem_addr, 32'h8);
    tick(); settle();
    chk("t3_mem_we_c2", 32'(mem_we), 0);
    tick(); settle();
    chk("t3_dm_ack_c3", 32'(dm_ack), 1);
    chk("t3_dm_rdata_c3", dm_rdata, 32'h0);
    tick(); dm_req = 0; dm_we = 0; dm_wdata = 0;
    tick();

    // 4: both held continuously; fetch wins after four data grants
    exp_seq[0] = 32'h200; exp_seq[1] = 32'h200; exp_seq[2] = 32'h200;
    exp_seq[3] = 32'h200; exp_seq[4] = 32'h100; exp_seq[5] = 32'h200;
    g = 0;
    tick(); if_req = 1; if_addr = 32'h100; dm_req = 1; dm_addr = 32'h200;
    for (int c = 0; c < 40 && g < 6; c++) begin
      settle();
      if (mem_en) begin
        chk($sformatf("t4_grant%0d", g), mem_addr, exp_seq[g]);
        if (g == 3) chk("t4_streak_sat", 32'(dut.streak_q), 4);
        if (g == 4) chk("t4_streak_clr", 32'(dut.streak_q), 0);
        g++;
      end
      tick();
    end
    chk("t4_grant_count", g, 6);
    if_req = 0; dm_req = 0;
    repeat (6) tick();
    chk("t4_if_rdata", if_rdata, 32'hA5A5_0100);

    // 5: fetch flushed during WAIT with a data request pending
    tick(); if_req = 1; if_addr = 32'h300;
    tick(); dm_req = 1; dm_we = 0; dm_addr = 32'h400; settle();
    chk("t5_mem_addr_c1", mem_addr, 32'h300);
    tick(); if_cancel = 1; if_req = 0;
    tick(); if_cancel = 0; settle();
    chk("t5_if_ack_c3", 32'(if_ack), 0);
    chk("t5_if_rdata_c3", if_rdata, 32'hA5A5_0100);
    tick(); settle();
    chk("t5_mem_en_c4", 32'(mem_en), 0);
    tick(); settle();
    chk("t5_mem_en_c5", 32'(mem_en), 1);
    chk("t5_mem_addr_c5", mem_addr, 32'h400);
    tick(); settle();
    tick(); settle();
    chk("t5_dm_ack_c7", 32'(dm_ack), 1);
    chk("t5_dm_rdata_c7", dm_rdata, 32'hA5A5_0400);
    tick(); dm_req = 0;
    tick();

    // 6: reset in the middle of a fetch, then a clean refetch
    tick(); if_req = 1; if_addr = 32'h500;
    tick();
    tick(); reset = 0; if_req = 0; settle();
    chk("t6_rst_mem_en", 32'(mem_en), 0);
    chk("t6_rst_mem_addr", mem_addr, 0);
    chk("t6_rst_if_ack", 32'(if_ack), 0);
    chk("t6_rst_dm_ack", 32'(dm_ack), 0);
    chk("t6_rst_if_rdata", if_rdata, 0);
    chk("t6_rst_dm_rdata", dm_rdata, 0);
    tick(); tick(); reset = 1;
    tick(); settle();
    chk("t6_no_stale_a", 32'(if_ack), 0);
    tick(); settle();
    chk("t6_no_stale_b", 32'(if_ack), 0);
    tick(); if_req = 1; if_addr = 32'h10; settle();
    chk("t6_stall_c0", 32'(if_stall), 1);
    tick(); settle();
    chk("t6_mem_en_c1", 32'(mem_en), 1);
    tick(); settle();
    chk("t6_if_ack_c2", 32'(if_ack), 0);
    tick(); settle();
    chk("t6_if_ack_c3", 32'(if_ack), 1);
    chk("t6_if_rdata_c3", if_rdata, 32'h00500093);
    tick(); if_req = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
